// File: rtl/ahb_lite_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ahb_lite_arbiter_if                                             |
// | Brief    : AHB-Lite address/data bundle for one bus port (master or slave) |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface ahb_lite_arbiter_if;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (
        output addr, trans, write, size, wdata,
        input  rdata, ready
    );

    modport slave (
        input  addr, trans, write, size, wdata,
        output rdata, ready
    );
endinterface
`default_nettype wire

// File: rtl/ahb_lite_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ahb_lite_arbiter                                                |
// | Brief    : Two-master / one-slave AHB-Lite arbiter with per-port hold      |
// |            stages. Optional macro AHB_ARB_BURST_LOCK_EN keeps the grant    |
// |            on the owner for SEQ bursts.                                    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ahb_lite_arbiter #(
    parameter int          FIXED_PRIO = 0,
    parameter logic [31:0] IDLE_ADDR  = 32'h0
) (
    input  wire logic          clk,
    input  wire logic          reset,
    ahb_lite_arbiter_if.slave  m0,
    ahb_lite_arbiter_if.slave  m1,
    ahb_lite_arbiter_if.master s
);

    localparam logic [1:0] C_TR_IDLE = 2'b00;
    localparam logic [1:0] C_TR_BUSY = 2'b01;
    localparam logic [1:0] C_TR_NSEQ = 2'b10;
    localparam logic [1:0] C_TR_SEQ  = 2'b11;
    localparam logic [2:0] C_SIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_DATA = 2'd2
    } port_state_t;

    port_state_t r_state     [2];
    port_state_t w_state_nxt [2];

    logic [31:0] r_hold_addr  [2];
    logic        r_hold_write [2];
    logic [2:0]  r_hold_size  [2];

    logic        r_own_vld;
    logic        r_own_id;
    logic        r_last_gnt;

    logic [31:0] w_live_addr  [2];
    logic [1:0]  w_live_trans [2];
    logic        w_live_write [2];
    logic [2:0]  w_live_size  [2];
    logic [31:0] w_live_wdata [2];

    logic [31:0] w_src_addr  [2];
    logic        w_src_write [2];
    logic [2:0]  w_src_size  [2];

    logic        w_ready    [2];
    logic        w_live_req [2];
    logic        w_req      [2];
    logic        w_win      [2];
    logic        w_take     [2];

    logic        w_gnt_vld;
    logic        w_gnt_id;
    logic        w_xfer;
    logic        w_accept;
    logic [1:0]  w_fwd_trans;

`ifdef AHB_ARB_BURST_LOCK_EN
    logic        r_lock_vld;
    logic        r_lock_id;
`endif

    always_comb begin
        w_live_addr[0]  = m0.addr;
        w_live_trans[0] = m0.trans;
        w_live_write[0] = m0.write;
        w_live_size[0]  = m0.size;
        w_live_wdata[0] = m0.wdata;
        w_live_addr[1]  = m1.addr;
        w_live_trans[1] = m1.trans;
        w_live_write[1] = m1.write;
        w_live_size[1]  = m1.size;
        w_live_wdata[1] = m1.wdata;
    end

    // A pending port presents its held address; otherwise the live bus is used.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_ready[i]    = (r_state[i] == ST_PEND) ? 1'b0 :
                            (r_state[i] == ST_DATA) ? s.ready : 1'b1;
            w_live_req[i] = (w_live_trans[i] == C_TR_NSEQ) || (w_live_trans[i] == C_TR_SEQ);
            w_req[i]      = !reset && ((r_state[i] == ST_PEND) || w_live_req[i]);
            if (r_state[i] == ST_PEND) begin
                w_src_addr[i]  = r_hold_addr[i];
                w_src_write[i] = r_hold_write[i];
                w_src_size[i]  = r_hold_size[i];
            end else begin
                w_src_addr[i]  = w_live_addr[i];
                w_src_write[i] = w_live_write[i];
                w_src_size[i]  = w_live_size[i];
            end
        end
    end

    always_comb begin
        w_gnt_vld   = w_req[0] || w_req[1];
        w_xfer      = w_gnt_vld;
        w_fwd_trans = C_TR_NSEQ;
        if (w_req[0] && w_req[1]) begin
            w_gnt_id = (FIXED_PRIO != 0) ? 1'b0 : ~r_last_gnt;
        end else begin
            w_gnt_id = !w_req[0];
        end
`ifdef AHB_ARB_BURST_LOCK_EN
        // Owner continuing its burst overrides arbitration; BUSY is shown but not transferred.
        if (!reset && r_lock_vld && (r_state[r_lock_id] == ST_DATA)) begin
            if (w_live_trans[r_lock_id] == C_TR_SEQ) begin
                w_gnt_vld   = 1'b1;
                w_gnt_id    = r_lock_id;
                w_xfer      = 1'b1;
                w_fwd_trans = C_TR_SEQ;
            end else if (w_live_trans[r_lock_id] == C_TR_BUSY) begin
                w_gnt_vld   = 1'b1;
                w_gnt_id    = r_lock_id;
                w_xfer      = 1'b0;
                w_fwd_trans = C_TR_BUSY;
            end
        end
`endif
        w_accept = w_xfer && s.ready;
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_win[i]       = w_accept && (w_gnt_id == 1'(i));
            w_take[i]      = w_ready[i] && w_live_req[i] && !w_win[i];
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                ST_IDLE: begin
                    if (w_win[i])       w_state_nxt[i] = ST_DATA;
                    else if (w_take[i]) w_state_nxt[i] = ST_PEND;
                end
                ST_PEND: begin
                    if (w_win[i])       w_state_nxt[i] = ST_DATA;
                end
                ST_DATA: begin
                    if (s.ready) begin
                        if (w_win[i])       w_state_nxt[i] = ST_DATA;
                        else if (w_take[i]) w_state_nxt[i] = ST_PEND;
                        else                w_state_nxt[i] = ST_IDLE;
                    end
                end
                default: w_state_nxt[i] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state[0] <= ST_IDLE;
            r_state[1] <= ST_IDLE;
        end else begin
            r_state[0] <= w_state_nxt[0];
            r_state[1] <= w_state_nxt[1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_hold_addr[i]  <= 32'h0;
                r_hold_write[i] <= 1'b0;
                r_hold_size[i]  <= 3'b000;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_win[i]) begin
                    r_hold_addr[i]  <= 32'h0;
                    r_hold_write[i] <= 1'b0;
                    r_hold_size[i]  <= 3'b000;
                end else if (w_take[i]) begin
                    r_hold_addr[i]  <= w_live_addr[i];
                    r_hold_write[i] <= w_live_write[i];
                    r_hold_size[i]  <= w_live_size[i];
                end
            end
        end
    end

    // The data-phase owner only changes when the current data phase completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_own_vld  <= 1'b0;
            r_own_id   <= 1'b0;
            r_last_gnt <= 1'b1;
        end else begin
            if (s.ready) begin
                r_own_vld <= w_accept;
                r_own_id  <= w_gnt_id;
            end
            if (w_accept) begin
                r_last_gnt <= w_gnt_id;
            end
        end
    end

`ifdef AHB_ARB_BURST_LOCK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lock_vld <= 1'b0;
            r_lock_id  <= 1'b0;
        end else if (s.ready) begin
            r_lock_vld <= w_accept;
            r_lock_id  <= w_gnt_id;
        end
    end
`endif

    assign s.addr  = w_gnt_vld ? w_src_addr[w_gnt_id]  : IDLE_ADDR;
    assign s.trans = w_gnt_vld ? w_fwd_trans           : C_TR_IDLE;
    assign s.write = w_gnt_vld ? w_src_write[w_gnt_id] : 1'b0;
    assign s.size  = w_gnt_vld ? w_src_size[w_gnt_id]  : C_SIZE_WORD;
    assign s.wdata = r_own_vld ? w_live_wdata[r_own_id] : 32'h0;

    assign m0.rdata = s.rdata;
    assign m1.rdata = s.rdata;
    assign m0.ready = w_ready[0];
    assign m1.ready = w_ready[1];

endmodule
`default_nettype wire
